// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in / serial-out transmitter.
// Accepts a WIDTH-bit word on a valid/ready handshake and emits it one bit per
// clock on sout, framed by sout_valid, with done pulsing on the final frame bit.
// Optional feature macro: PISO_PARITY_EN appends one even-parity bit per frame.
//
// Handshake: a word is accepted at a rising edge where load_valid && load_ready;
// load_ready depends only on state/count (never on load_valid), and a held
// load_valid while load_ready is low has no effect on the frame in flight.
module piso_serializer #(
   parameter int WIDTH     = 3,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   input  logic [WIDTH-1:0] load_data,
   output logic             load_ready,
   output logic             sout,
   output logic             sout_valid,
   output logic             done,
   output logic [1:0]       dbg_state
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_PARITY = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             sout_q, sout_d;
   logic             valid_q, valid_d;
   logic             done_q, done_d;
`ifdef PISO_PARITY_EN
   logic             par_q, par_d;
`endif

   logic             accept;
   logic             next_bit;
   logic [WIDTH-1:0] shreg_shifted;
   logic [CW-1:0]    cnt_inc;

   // Ready window: idle, or the cycle carrying the final bit of the frame
   always_comb begin
`ifdef PISO_PARITY_EN
      load_ready = (state_q == ST_IDLE) || (state_q == ST_PARITY);
`else
      load_ready = (state_q == ST_IDLE) ||
                   ((state_q == ST_SHIFT) && (cnt_q == LAST));
`endif
   end

   assign accept = load_valid & load_ready;

   // Shift-path helpers: the bit on deck is kept at the outgoing end of shreg_q
   always_comb begin
      next_bit      = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
      shreg_shifted = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
      cnt_inc       = cnt_q + CW'(1);
   end

   // Next-state and next-output logic; a load overrides the frame-end decision
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      sout_d  = 1'b0;
      valid_d = 1'b0;
      done_d  = 1'b0;
`ifdef PISO_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
         ST_SHIFT: begin
            if (cnt_q != LAST) begin
               sout_d  = next_bit;
               valid_d = 1'b1;
               cnt_d   = cnt_inc;
               shreg_d = shreg_shifted;
`ifdef PISO_PARITY_EN
               done_d  = 1'b0;
`else
               done_d  = (cnt_inc == LAST);
`endif
            end else begin
`ifdef PISO_PARITY_EN
               state_d = ST_PARITY;
               sout_d  = par_q;
               valid_d = 1'b1;
               done_d  = 1'b1;
`else
               state_d = ST_IDLE;
`endif
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // First bit goes straight to the output register so it appears the
      // cycle after the accept edge; the rest of the word waits in shreg.
      if (accept) begin
         state_d = ST_SHIFT;
         cnt_d   = '0;
         sout_d  = MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
         valid_d = 1'b1;
         done_d  = 1'b0;
         shreg_d = MSB_FIRST ? (load_data << 1) : (load_data >> 1);
`ifdef PISO_PARITY_EN
         par_d   = ^load_data;
`endif
      end
   end

   // State and registered outputs; synchronous reset aborts any frame
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
         sout_q  <= 1'b0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
`ifdef PISO_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         sout_q  <= sout_d;
         valid_q <= valid_d;
         done_q  <= done_d;
`ifdef PISO_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   assign sout       = sout_q;
   assign sout_valid = valid_q;
   assign done       = done_q;
   assign dbg_state  = state_q;

endmodule
